mips_multicycle_core: RTL and testbench
=======================================

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 0: byte address loaded into pc on reset.
REQ-002 SHALL have parameter ADDR_W, default 32: width of pc and mem_addr, legal range 8..32.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  memory request valid.
REQ-006 SHALL have port mem_we  output  1  1 = store, 0 = load or fetch.
REQ-007 SHALL have port mem_addr  output  ADDR_W  byte address, word-aligned.
REQ-008 SHALL have port mem_wdata  output  32  store data.
REQ-009 SHALL have port mem_rdata  input  32  load/fetch data, valid when mem_ready=1.
REQ-010 SHALL have port mem_ready  input  1  completes the pending request this cycle.
REQ-011 SHALL have port pc  output  ADDR_W  current program counter.
REQ-012 SHALL have port state  output  3  FSM encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-013 SHALL have port trap  output  1  high while in TRAP.

Function
REQ-014 SHALL decode opcodes R-type(0), j(2), beq(4), bne(5), addi(8), lw(35), sw(43); any other opcode -> TRAP from DECODE.
REQ-015 SHALL decode R-type funct add(0x20), sub(0x22), and(0x24), or(0x25), slt(0x2A); any other funct -> TRAP from DECODE.
REQ-016 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=pc, hold until mem_ready=1, then latch IR, set pc=pc+4 (mod 2^ADDR_W), go DECODE.
REQ-017 DECODE SHALL take one cycle, latch A=reg[rs], B=reg[rt], sign-extend imm16 to 32 bits, go EXEC or TRAP.
REQ-018 EXEC SHALL take one cycle: R-type/addi -> WB; lw/sw compute A+sext(imm) -> MEM; beq/bne compare A,B -> FETCH; j -> FETCH.
REQ-019 Taken beq (A==B) or bne (A!=B) SHALL set pc = pc + (sext(imm)<<2), where pc is already the incremented value.
REQ-020 j SHALL set pc = {pc[ADDR_W-1:28] when ADDR_W>28, target26, 2'b00}, truncated to ADDR_W.
REQ-021 MEM SHALL drive mem_req=1, mem_addr=effective address, mem_we=1 and mem_wdata=B for sw; hold until mem_ready=1; lw latches mem_rdata -> WB; sw -> FETCH.
REQ-022 lw/sw with effective address bits [1:0] != 0 SHALL go to TRAP from EXEC, with no memory request issued.
REQ-023 WB SHALL write rd for R-type, rt for addi/lw, then go FETCH; writes to r0 SHALL be discarded and r0 SHALL always read 0.
REQ-024 Arithmetic SHALL wrap mod 2^32 with no overflow exception; slt SHALL be a signed compare producing 0 or 1.
REQ-025 mem_addr, mem_we and mem_wdata SHALL be stable while mem_req=1 and mem_ready=0; mem_ready with mem_req=0 SHALL be ignored.
REQ-026 With zero-wait memory, cycles per instruction SHALL be: R-type/addi 4, lw 5, sw 4, beq/bne/j 3; each wait cycle adds 1.
REQ-027 TRAP SHALL be absorbing until rst, with mem_req=0 and pc frozen at the value after the faulting fetch.

Reset
REQ-028 rst=1 SHALL set pc=RESET_PC, state=FETCH, mem_req=0, trap=0, IR/A/B/MDR=0, and all 32 registers=0.
REQ-029 rst asserted during a pending memory request SHALL drop mem_req on the next cycle and abandon the transaction with no register write.
REQ-030 In the first cycle after rst deasserts, the core SHALL drive mem_req=1 with mem_addr=RESET_PC.

Configuration
REQ-031 Macro MIPS_MC_PERF_EN SHALL, when defined, add outputs cycle_cnt (32) and instret (32).
REQ-032 cycle_cnt SHALL increment every non-reset cycle outside TRAP; instret SHALL increment on each instruction's final state. Both SHALL be reset to 0 and wrap at 2^32.
REQ-033 Without MIPS_MC_PERF_EN, these ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-034 addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 with zero-wait memory -> r3=12, pc=12 after 12 cycles.
REQ-035 sw r3,8(r0), then lw r4,8(r0), with mem_ready delayed by 2 cycles on every request -> r4=12, and address/data held stable throughout each wait.
REQ-036 beq r1,r1,-1 at 0x20 -> pc returns to 0x20 every 3 cycles; bne r1,r1,+4 -> falls through to 0x24.
REQ-037 Opcode 0x3F at 0x10 -> trap=1 two cycles after the fetch completes, pc=0x14, mem_req stays 0 for 100 cycles.
REQ-038 lw r5,2(r0) -> TRAP with no MEM request; rst pulsed during a FETCH wait -> mem_req=0 next cycle, then a fetch at RESET_PC.
REQ-039 With MIPS_MC_PERF_EN, running the REQ-034 program -> instret=3, cycle_cnt=12; addi r0,r0,9 -> r0 still reads 0.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
// Multicycle MIPS subset core (add, sub, and, or, slt, addi, lw, sw, beq, bne, j)
// with a single request/ready memory port shared by instruction fetch and data access.
//
// Parameters
//   RESET_PC  byte address loaded into pc on reset (truncated to ADDR_W)
//   ADDR_W    width of pc and mem_addr, 8..32
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   mem_req    memory request valid (FETCH or MEM state, suppressed while rst=1)
//   mem_we     1 = store, 0 = load/fetch
//   mem_addr   word-aligned byte address
//   mem_wdata  store data
//   mem_rdata  load/fetch data, valid when mem_ready=1
//   mem_ready  completes the pending request in this cycle
//   pc         current program counter
//   state      FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   trap       high while in TRAP
//
// Optional feature (macro MIPS_MC_PERF_EN)
//   cycle_cnt  cycles spent outside reset and TRAP
//   instret    retired instructions

module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              trap
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t      st;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mdr;
    logic [31:0] alu_out;
    logic [31:0] rf [32];

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [25:0] target;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign target   = ir[25:0];

    logic is_rtype, is_j, is_beq, is_bne, is_addi, is_lw, is_sw;
    logic funct_ok, decode_ok;

    always_comb begin
        is_rtype  = (opcode == OP_RTYPE);
        is_j      = (opcode == OP_J);
        is_beq    = (opcode == OP_BEQ);
        is_bne    = (opcode == OP_BNE);
        is_addi   = (opcode == OP_ADDI);
        is_lw     = (opcode == OP_LW);
        is_sw     = (opcode == OP_SW);
        funct_ok  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);
        decode_ok = (is_rtype && funct_ok) || is_j || is_beq || is_bne ||
                    is_addi || is_lw || is_sw;
    end

    // Register file read ports; r0 is forced to zero on read as well as never written
    logic [31:0] rf_a, rf_b;
    assign rf_a = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rf_b = (rt == 5'd0) ? 32'd0 : rf[rt];

    // Datapath
    logic [31:0]       alu_r;
    logic [31:0]       ea;
    logic              br_taken;
    logic [31:0]       br_off;
    logic [ADDR_W-1:0] br_target;
    logic [31:0]       pc_ext;
    logic [31:0]       j_full;
    logic [ADDR_W-1:0] j_target;
    logic [4:0]        wb_dest;
    logic [31:0]       wb_val;

    always_comb begin
        alu_r = '0;
        case (funct)
            FN_ADD:  alu_r = a + b;
            FN_SUB:  alu_r = a - b;
            FN_AND:  alu_r = a & b;
            FN_OR:   alu_r = a | b;
            FN_SLT:  alu_r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: alu_r = '0;
        endcase
    end

    assign ea        = a + imm_sext;
    assign br_taken  = (is_beq && (a == b)) || (is_bne && (a != b));
    assign br_off    = {imm_sext[29:0], 2'b00};
    assign br_target = pc + br_off[ADDR_W-1:0];
    // Upper pc bits only survive when ADDR_W > 28; zero-extending first keeps one
    // expression valid across the whole ADDR_W range.
    assign pc_ext    = 32'(pc);
    assign j_full    = {pc_ext[31:28], target, 2'b00};
    assign j_target  = j_full[ADDR_W-1:0];
    assign wb_dest   = is_rtype ? rd : rt;
    assign wb_val    = is_lw ? mdr : alu_out;

    always_ff @(posedge CLK) begin
        if (rst) begin
            st      <= S_FETCH;
            pc      <= RESET_PC[ADDR_W-1:0];
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            mdr     <= '0;
            alu_out <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (st)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + PC_STEP;
                        st <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a  <= rf_a;
                    b  <= rf_b;
                    st <= decode_ok ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    if (is_rtype) begin
                        alu_out <= alu_r;
                        st      <= S_WB;
                    end else if (is_addi) begin
                        alu_out <= ea;
                        st      <= S_WB;
                    end else if (is_lw || is_sw) begin
                        alu_out <= ea;
                        st      <= (ea[1:0] != 2'b00) ? S_TRAP : S_MEM;
                    end else if (is_beq || is_bne) begin
                        if (br_taken) begin
                            pc <= br_target;
                        end
                        st <= S_FETCH;
                    end else if (is_j) begin
                        pc <= j_target;
                        st <= S_FETCH;
                    end else begin
                        st <= S_TRAP;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_lw) begin
                            mdr <= mem_rdata;
                            st  <= S_WB;
                        end else begin
                            st <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (wb_dest != 5'd0) begin
                        rf[wb_dest] <= wb_val;
                    end
                    st <= S_FETCH;
                end
                S_TRAP: st <= S_TRAP;
                default: st <= S_TRAP;
            endcase
        end
    end

    // Memory port is a pure decode of the state register. mem_req is also gated
    // by rst so that the request disappears while reset is held and reappears in
    // the very first cycle after release.
    assign mem_req   = !rst && ((st == S_FETCH) || (st == S_MEM));
    assign mem_we    = (st == S_MEM) && is_sw;
    assign mem_addr  = (st == S_MEM) ? alu_out[ADDR_W-1:0] : pc;
    assign mem_wdata = b;
    assign state     = st;
    assign trap      = (st == S_TRAP);

`ifdef MIPS_MC_PERF_EN
    // Retirement happens in the last state an instruction visits.
    logic retire;
    assign retire = (st == S_WB) ||
                    ((st == S_EXEC) && (is_beq || is_bne || is_j)) ||
                    ((st == S_MEM) && mem_ready && is_sw);

    always_ff @(posedge CLK) begin
        if (rst) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (st != S_TRAP) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (retire) begin
                instret <= instret + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

    logic        CLK;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        trap;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret;
`endif

    mips_multicycle_core #(
        .RESET_PC(32'd0),
        .ADDR_W(32)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc(pc),
        .state(state),
        .trap(trap)
`ifdef MIPS_MC_PERF_EN
        ,
        .cycle_cnt(cycle_cnt),
        .instret(instret)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total;
    int bad;

    // Word memory model, 64 words (byte addresses 0x00..0xFF)
    logic [31:0] mem [64];
    int          mem_wait;
    logic        idle_ready;
    int          wait_cnt;
    logic        pend;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_we;
    int          stab_err;
    int          n_reqcyc;
    int          n_served;

    // One clock cycle: memory responds on the falling edge, checks follow 1 time unit after the rising edge
    task automatic step();
        @(negedge CLK);
        if (mem_req === 1'b1) begin
            n_reqcyc++;
            if (pend && (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata))
                stab_err++;
            if (!pend) begin
                s_addr  = mem_addr;
                s_we    = mem_we;
                s_wdata = mem_wdata;
            end
            if (wait_cnt >= mem_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[7:2]];
                if (mem_we === 1'b1) mem[mem_addr[7:2]] = mem_wdata;
                n_served++;
                wait_cnt = 0;
                pend     = 1'b0;
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
                pend = 1'b1;
            end
        end else begin
            mem_ready = idle_ready;
            mem_rdata = 32'hFC00_0000;
            wait_cnt  = 0;
            pend      = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold reset, then fill memory with an illegal opcode so stray fetches trap
    task automatic begin_reset();
        rst = 1'b1;
        step();
        for (int i = 0; i < 64; i++) mem[i] = 32'hFC00_0000;
        wait_cnt = 0; pend = 1'b0; stab_err = 0; n_reqcyc = 0; n_served = 0;
        idle_ready = 1'b0;
    endtask

    task automatic end_reset();
        step();
        rst = 1'b0;
        #1;
        n_reqcyc = 0; n_served = 0;
    endtask

    task automatic test_reset();
        mem_wait = 0;
        begin_reset();
        mem[0] = 32'h2001_0005;
        step();
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (trap !== 1'b0) begin bad++; $display("FAIL reset_trap: got %b want 0", trap); end
`ifdef MIPS_MC_PERF_EN
        total++; if (cycle_cnt !== 32'd0 || instret !== 32'd0) begin bad++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", cycle_cnt, instret); end
`endif
        rst = 1'b0;
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'd0 || mem_we !== 1'b0) begin bad++;
            $display("FAIL first_fetch: got req=%b addr=%h we=%b want 1/00000000/0", mem_req, mem_addr, mem_we); end
    endtask

    // addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,0x40(r0); spin
    task automatic test_arith();
        mem_wait = 0;
        begin_reset();
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_0007;
        mem[2] = 32'h0022_1820;
        mem[3] = 32'hAC03_0040;
        mem[4] = 32'h1000_FFFF;
        mem[16] = 32'hDEAD_BEEF;
        end_reset();
        steps(12);
        total++; if (pc !== 32'd12 || state !== 3'd0) begin bad++;
            $display("FAIL arith_pc: got pc=%h state=%0d want 0000000c/0", pc, state); end
`ifdef MIPS_MC_PERF_EN
        total++; if (instret !== 32'd3 || cycle_cnt !== 32'd12) begin bad++;
            $display("FAIL arith_perf: got instret=%0d cycles=%0d want 3/12", instret, cycle_cnt); end
`endif
        steps(4);
        total++; if (mem[16] !== 32'd12) begin bad++; $display("FAIL arith_r3: got %h want 0000000c", mem[16]); end
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL arith_sw_pc: got %h want 00000010", pc); end
    endtask

    // sub/and/or/slt/add-wrap with negative operand; addi r0 then stored to check r0 reads 0
    task automatic test_alu();
        mem_wait = 0;
        begin_reset();
        mem[0]  = 32'h2001_FFFD;
        mem[1]  = 32'h2002_0005;
        mem[2]  = 32'h0022_1822;
        mem[3]  = 32'h0022_2024;
        mem[4]  = 32'h0022_2825;
        mem[5]  = 32'h0022_302A;
        mem[6]  = 32'h0041_382A;
        mem[7]  = 32'h0021_4020;
        mem[8]  = 32'h2000_0009;
        mem[9]  = 32'hAC03_0080;
        mem[10] = 32'hAC04_0084;
        mem[11] = 32'hAC05_0088;
        mem[12] = 32'hAC06_008C;
        mem[13] = 32'hAC07_0090;
        mem[14] = 32'hAC08_0094;
        mem[15] = 32'hAC00_0098;
        mem[16] = 32'h1000_FFFF;
        for (int i = 32; i < 39; i++) mem[i] = 32'hDEAD_BEEF;
        end_reset();
        idle_ready = 1'b1;
        steps(79);
        total++; if (mem[32] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL alu_sub: got %h want fffffff8", mem[32]); end
        total++; if (mem[33] !== 32'h0000_0005) begin bad++; $display("FAIL alu_and: got %h want 00000005", mem[33]); end
        total++; if (mem[34] !== 32'hFFFF_FFFD) begin bad++; $display("FAIL alu_or: got %h want fffffffd", mem[34]); end
        total++; if (mem[35] !== 32'h0000_0001) begin bad++; $display("FAIL alu_slt_lt: got %h want 00000001", mem[35]); end
        total++; if (mem[36] !== 32'h0000_0000) begin bad++; $display("FAIL alu_slt_ge: got %h want 00000000", mem[36]); end
        total++; if (mem[37] !== 32'hFFFF_FFFA) begin bad++; $display("FAIL alu_add_wrap: got %h want fffffffa", mem[37]); end
        total++; if (mem[38] !== 32'h0000_0000) begin bad++; $display("FAIL alu_r0: got %h want 00000000", mem[38]); end
        total++; if (pc !== 32'h40 || state !== 3'd0) begin bad++;
            $display("FAIL alu_spin_pc: got pc=%h state=%0d want 00000040/0", pc, state); end
`ifdef MIPS_MC_PERF_EN
        total++; if (instret !== 32'd21 || cycle_cnt !== 32'd79) begin bad++;
            $display("FAIL alu_perf: got instret=%0d cycles=%0d want 21/79", instret, cycle_cnt); end
`endif
    endtask

    // Two wait cycles on every request: j 0x40; addi r3,r0,12; sw r3,8(r0); lw r4,8(r0); sw r4,0x84(r0)
    task automatic test_wait_states();
        mem_wait = 2;
        begin_reset();
        mem[0]  = 32'h0800_0010;
        mem[2]  = 32'hDEAD_BEEF;
        mem[16] = 32'h2003_000C;
        mem[17] = 32'hAC03_0008;
        mem[18] = 32'h8C04_0008;
        mem[19] = 32'hAC04_0084;
        mem[20] = 32'h1000_FFFF;
        mem[33] = 32'h0;
        end_reset();
        steps(36);
        total++; if (pc !== 32'h50 || state !== 3'd0) begin bad++;
            $display("FAIL wait_timing: got pc=%h state=%0d want 00000050/0", pc, state); end
        total++; if (mem[2] !== 32'd12) begin bad++; $display("FAIL wait_sw: got %h want 0000000c", mem[2]); end
        total++; if (mem[33] !== 32'd12) begin bad++; $display("FAIL wait_lw_r4: got %h want 0000000c", mem[33]); end
        total++; if (stab_err !== 0) begin bad++; $display("FAIL wait_stable: got %0d changes want 0", stab_err); end
        mem_wait = 0;
    endtask

    task automatic test_branch();
        mem_wait = 0;
        // beq r1,r1,-1 at 0x20 loops every 3 cycles
        begin_reset();
        mem[0] = 32'h0800_0008;
        mem[8] = 32'h1021_FFFF;
        end_reset();
        steps(3);
        total++; if (pc !== 32'h20) begin bad++; $display("FAIL j_target: got %h want 00000020", pc); end
        step();
        total++; if (pc !== 32'h24 || state !== 3'd1) begin bad++;
            $display("FAIL beq_fetch: got pc=%h state=%0d want 00000024/1", pc, state); end
        steps(2);
        total++; if (pc !== 32'h20 || state !== 3'd0) begin bad++;
            $display("FAIL beq_loop1: got pc=%h state=%0d want 00000020/0", pc, state); end
        steps(3);
        total++; if (pc !== 32'h20 || state !== 3'd0) begin bad++;
            $display("FAIL beq_loop2: got pc=%h state=%0d want 00000020/0", pc, state); end
        // bne not taken, addi, bne taken forward, beq not taken
        begin_reset();
        mem[0]  = 32'h0800_0008;
        mem[8]  = 32'h1421_0004;
        mem[9]  = 32'h2001_0001;
        mem[10] = 32'h1420_0002;
        mem[13] = 32'h1020_0005;
        mem[14] = 32'h1000_FFFF;
        end_reset();
        steps(6);
        total++; if (pc !== 32'h24) begin bad++; $display("FAIL bne_fallthrough: got %h want 00000024", pc); end
        steps(7);
        total++; if (pc !== 32'h34) begin bad++; $display("FAIL bne_taken: got %h want 00000034", pc); end
        steps(3);
        total++; if (pc !== 32'h38 || state !== 3'd0) begin bad++;
            $display("FAIL beq_not_taken: got pc=%h state=%0d want 00000038/0", pc, state); end
    endtask

    task automatic test_trap_opcode();
        int req_seen;
        mem_wait = 0;
        begin_reset();
        mem[0] = 32'h0800_0004;
        mem[4] = 32'hFC00_0000;
        end_reset();
        steps(4);
        total++; if (trap !== 1'b0 || state !== 3'd1 || pc !== 32'h14) begin bad++;
            $display("FAIL trap_decode: got trap=%b state=%0d pc=%h want 0/1/00000014", trap, state, pc); end
        step();
        total++; if (trap !== 1'b1 || state !== 3'd5) begin bad++;
            $display("FAIL trap_enter: got trap=%b state=%0d want 1/5", trap, state); end
        idle_ready = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (mem_req !== 1'b0 || trap !== 1'b1) req_seen++;
        end
        total++; if (req_seen !== 0) begin bad++; $display("FAIL trap_absorb: got %0d bad cycles want 0", req_seen); end
        total++; if (pc !== 32'h14) begin bad++; $display("FAIL trap_pc: got %h want 00000014", pc); end
`ifdef MIPS_MC_PERF_EN
        total++; if (cycle_cnt !== 32'd5 || instret !== 32'd1) begin bad++;
            $display("FAIL trap_perf: got cycles=%0d instret=%0d want 5/1", cycle_cnt, instret); end
`endif
        // unsupported funct (addu)
        begin_reset();
        mem[0] = 32'h0022_1821;
        end_reset();
        steps(2);
        total++; if (trap !== 1'b1 || pc !== 32'h4) begin bad++;
            $display("FAIL trap_funct: got trap=%b pc=%h want 1/00000004", trap, pc); end
    endtask

    task automatic test_misaligned();
        mem_wait = 0;
        begin_reset();
        mem[0] = 32'h8C05_0002;
        end_reset();
        steps(20);
        total++; if (state !== 3'd5 || pc !== 32'h4) begin bad++;
            $display("FAIL lw_misaligned: got state=%0d pc=%h want 5/00000004", state, pc); end
        total++; if (n_reqcyc !== 1) begin bad++; $display("FAIL lw_misaligned_req: got %0d req cycles want 1", n_reqcyc); end
        begin_reset();
        mem[0] = 32'hAC05_0001;
        end_reset();
        steps(20);
        total++; if (state !== 3'd5 || n_reqcyc !== 1 || mem[0] !== 32'hAC05_0001) begin bad++;
            $display("FAIL sw_misaligned: got state=%0d req=%0d mem0=%h want 5/1/ac050001", state, n_reqcyc, mem[0]); end
    endtask

    task automatic test_reset_mid_fetch();
        mem_wait = 3;
        begin_reset();
        mem[0] = 32'h2001_0005;
        mem[1] = 32'hAC01_0080;
        mem[2] = 32'h1000_FFFF;
        mem[32] = 32'hDEAD_BEEF;
        end_reset();
        steps(2);
        rst = 1'b1;
        step();
        total++; if (mem_req !== 1'b0 || n_served !== 0 || state !== 3'd0 || pc !== 32'd0) begin bad++;
            $display("FAIL rst_mid_fetch: got req=%b served=%0d state=%0d pc=%h want 0/0/0/00000000", mem_req, n_served, state, pc); end
        rst = 1'b0;
        #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin bad++;
            $display("FAIL rst_refetch: got req=%b addr=%h want 1/00000000", mem_req, mem_addr); end
        steps(17);
        total++; if (mem[32] !== 32'd5 || pc !== 32'h8) begin bad++;
            $display("FAIL rst_resume: got mem=%h pc=%h want 00000005/00000008", mem[32], pc); end
        mem_wait = 0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        mem_wait = 0;
        idle_ready = 1'b0;
        wait_cnt = 0;
        pend = 1'b0;
        s_addr = '0;
        s_wdata = '0;
        s_we = 1'b0;
        stab_err = 0;
        n_reqcyc = 0;
        n_served = 0;
        @(posedge CLK);
        #1;
        test_reset();
        test_arith();
        test_alu();
        test_wait_states();
        test_branch();
        test_trap_opcode();
        test_misaligned();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
